// File: rtl/queue_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : queue_reader_if
// Description : Bundles the queue dequeue port and the framed output stream
//               of the queue reader.
//               master modport : the reader (drives q_dequeue and m_*)
//               slave modport  : the environment (queue read side plus
//                                stream consumer)
//   q_empty    queue empty flag               (slave -> master)
//   q_dequeue  dequeue strobe                 (master -> slave)
//   q_data     queue read data, one-cycle lag (slave -> master)
//   m_valid    output word valid              (master -> slave)
//   m_ready    consumer accepts word          (slave -> master)
//   m_data     output word                    (master -> slave)
//   m_last     last word of frame             (master -> slave)
//   m_idx      word index within frame        (master -> slave)
// Revision    : 1.0 - initial release
// ============================================================================
interface queue_reader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 16
);
  logic                  q_empty;
  logic                  q_dequeue;
  logic [DATA_WIDTH-1:0] q_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [IDX_WIDTH-1:0]  m_idx;

  modport master (
    input  q_empty, q_data, m_ready,
    output q_dequeue, m_valid, m_data, m_last, m_idx
  );

  modport slave (
    output q_empty, q_data, m_ready,
    input  q_dequeue, m_valid, m_data, m_last, m_idx
  );
endinterface
`default_nettype wire

// File: rtl/queue_reader.sv
`default_nettype none
// ============================================================================
// Module      : queue_reader
// Description : Drains the on-chip queue through its dequeue port and
//               presents the words as a registered valid/ready stream with
//               frame framing. Absorbs the queue's one-cycle read latency
//               with a 2-entry output buffer so one word per clock is
//               sustained.
// Ports       : clk    - sole clock, rising edge
//               reset  - synchronous, active-high reset
//               bus    - queue_reader_if.master (queue read side + stream)
// Revision    : 1.0 - initial release
// ============================================================================
module queue_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_LEN  = 16,
  parameter int IDX_WIDTH  = 16
) (
  input wire             clk,
  input wire             reset,
  queue_reader_if.master bus
);

  localparam logic [IDX_WIDTH-1:0] c_last_idx = IDX_WIDTH'(FRAME_LEN - 1);
  localparam logic [IDX_WIDTH-1:0] c_idx_one  = IDX_WIDTH'(1);

  // Buffer state: r_head is the word on m_data, r_tail the second entry.
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  logic [IDX_WIDTH-1:0]  r_idx;

  logic                  w_valid;
  logic                  w_xfer;
  logic [2:0]            w_pend;
  logic [2:0]            w_limit;
  logic                  w_dequeue;
  logic [1:0]            w_occ_next;
  logic                  w_load_head;
  logic                  w_load_tail;
  logic [DATA_WIDTH-1:0] w_head_next;

  assign w_valid = (r_occ != 2'd0);
  assign w_xfer  = w_valid & bus.m_ready;

  // Words already owned (buffered + arriving) must leave room for one more
  // after this cycle's transfer, otherwise the buffer could overflow.
  assign w_pend    = {1'b0, r_occ} + {2'b00, r_inflight};
  assign w_limit   = 3'd1 + {2'b00, w_xfer};
  assign w_dequeue = !reset && !bus.q_empty && (w_pend <= w_limit);

  assign w_occ_next = r_occ + {1'b0, r_inflight} - {1'b0, w_xfer};

  // Head/tail update. The arriving word goes to the head when the buffer is
  // (or is about to become) empty of older words, otherwise to the tail.
  always_comb begin
    w_load_head = 1'b0;
    w_load_tail = 1'b0;
    w_head_next = r_tail;
    if (w_xfer) begin
      if (r_occ == 2'd2) begin
        w_load_head = 1'b1;
        w_head_next = r_tail;
        w_load_tail = r_inflight;
      end else if (r_inflight) begin
        w_load_head = 1'b1;
        w_head_next = bus.q_data;
      end
    end else if (r_inflight) begin
      if (r_occ == 2'd0) begin
        w_load_head = 1'b1;
        w_head_next = bus.q_data;
      end else begin
        w_load_tail = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_idx      <= '0;
    end else begin
      r_inflight <= w_dequeue;
      r_occ      <= w_occ_next;
      if (w_load_head) begin
        r_head <= w_head_next;
      end
      if (w_load_tail) begin
        r_tail <= bus.q_data;
      end
      if (w_xfer) begin
        r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_idx_one;
      end
    end
  end

  assign bus.q_dequeue = w_dequeue;
  assign bus.m_valid   = w_valid;
  assign bus.m_data    = r_head;
  assign bus.m_idx     = r_idx;
  assign bus.m_last    = w_valid & (r_idx == c_last_idx);

endmodule
`default_nettype wire
